spr_dma_ctrl: RTL

- OAM (sprite) DMA sequencer on the CPU-clock bus domain.
- Detects a CPU write to the DMA trigger register, requests bus ownership, then copies a 256-byte CPU page to the PPU OAM data port.
- Each byte is transferred as a read/write pair through the arbiter's spr request channel.
- Sits between the bus snoop (bus addr/wn/wdata) and the arbiter's spr_req/gnt/addr/wn/wdata/rdata ports. Also exports busy/done status.

---
 rtl/spr_dma_ctrl_if.sv | 23 ++
 rtl/spr_dma_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/spr_dma_ctrl_if.sv
// Bus-snoop inputs and the arbiter's sprite request channel used by spr_dma_ctrl.
// master = DMA sequencer side, slave = arbiter/bus side.
interface spr_dma_ctrl_if;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;

  modport master (
    input  bus_addr, bus_wn, bus_wdata, spr_gnt, spr_rdata,
    output spr_req, spr_addr, spr_wn, spr_wdata
  );

  modport slave (
    output bus_addr, bus_wn, bus_wdata, spr_gnt, spr_rdata,
    input  spr_req, spr_addr, spr_wn, spr_wdata
  );
endinterface

// File: rtl/spr_dma_ctrl.sv
// OAM sprite DMA sequencer: a write to TRIG_ADDR copies one CPU page to DST_ADDR as read/write pairs.
// Optional macro SPR_DMA_ALIGN_EN adds the 2A03-style parity alignment wait before the first read.
module spr_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DST_ADDR  = 16'h2004,
  parameter int unsigned XFER_CNT  = 256
) (
  input  logic           i_clk,
  input  logic           i_rst,
  spr_dma_ctrl_if.master bus,
  output logic           o_busy,
  output logic           o_done
);
  localparam logic [7:0] LAST_IDX = 8'(XFER_CNT - 1);

`ifdef SPR_DMA_ALIGN_EN
  typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic        wn_q, wn_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        trig;

`ifdef SPR_DMA_ALIGN_EN
  logic par_q;
  logic align_q, align_d;
`endif

  assign trig = (bus.bus_addr == TRIG_ADDR) && !bus.bus_wn;

  // Outputs are registered from the next-state decision, so the access
  // presented in a cycle always matches the state that evaluates its grant.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wn_d    = wn_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SPR_DMA_ALIGN_EN
    align_d = align_q;
`endif
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        wn_d  = 1'b1;
        if (trig) begin
          page_d = bus.bus_wdata;
          idx_d  = 8'h00;
          busy_d = 1'b1;
`ifdef SPR_DMA_ALIGN_EN
          state_d = ALIGN;
          align_d = par_q;
`else
          state_d = RD;
          req_d   = 1'b1;
          addr_d  = {bus.bus_wdata, 8'h00};
`endif
        end
      end
`ifdef SPR_DMA_ALIGN_EN
      ALIGN: begin
        if (align_q) begin
          align_d = 1'b0;
        end else begin
          state_d = RD;
          req_d   = 1'b1;
          addr_d  = {page_q, idx_q};
          wn_d    = 1'b1;
        end
      end
`endif
      RD: begin
        if (bus.spr_gnt) begin
          state_d = WR;
          addr_d  = DST_ADDR;
          wn_d    = 1'b0;
          wdata_d = bus.spr_rdata;
        end
      end
      WR: begin
        if (bus.spr_gnt) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            req_d   = 1'b0;
            wn_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RD;
            idx_d   = idx_q + 8'd1;
            addr_d  = {page_q, idx_q + 8'd1};
            wn_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      req_q   <= 1'b0;
      addr_q  <= 16'h0000;
      wn_q    <= 1'b1;
      wdata_q <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wn_q    <= wn_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SPR_DMA_ALIGN_EN
  // Free-running CPU cycle parity; an odd trigger cycle costs one extra ALIGN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par_q   <= 1'b0;
      align_q <= 1'b0;
    end else begin
      par_q   <= ~par_q;
      align_q <= align_d;
    end
  end
`endif

  assign bus.spr_req   = req_q;
  assign bus.spr_addr  = addr_q;
  assign bus.spr_wn    = wn_q;
  assign bus.spr_wdata = wdata_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
endmodule
